// File: rtl/vx_scoreboard_mp.sv
// Register scoreboard with per-warp reservations and multi-port writeback.
// Hazard lookup is precomputed one cycle ahead from the next-state table.
module vx_scoreboard_mp #(
  parameter int NUM_WARPS        = 4,
  parameter int NUM_REGS         = 64,
  parameter int NUM_WB           = 2,
  parameter int DEADLOCK_TIMEOUT = 10000,
  localparam int WW = $clog2(NUM_WARPS),
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [WW-1:0]        issue_wid,
  input  logic                 issue_wb,
  input  logic [RW-1:0]        issue_rd,
  input  logic [WW-1:0]        next_wid,
  input  logic [RW-1:0]        next_rd,
  input  logic [RW-1:0]        next_rs1,
  input  logic [RW-1:0]        next_rs2,
  input  logic [RW-1:0]        next_rs3,
  input  logic [NUM_WB-1:0]    wb_valid,
  input  logic [NUM_WB-1:0]    wb_eop,
  input  logic [NUM_WB*WW-1:0] wb_wid,
  input  logic [NUM_WB*RW-1:0] wb_rd,
  output logic [NUM_WB-1:0]    wb_ready,
  input  logic                 flush_valid,
  input  logic [WW-1:0]        flush_wid,
  output logic [NUM_WARPS-1:0] warp_busy,
  output logic                 err_release,
  output logic                 deadlock
);

  localparam logic [31:0] TO = 32'(DEADLOCK_TIMEOUT);

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse_q, inuse_d;
  logic [3:0]           lk_q, lk_d;
  logic [NUM_WARPS-1:0] busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 dead_q, dead_d;
  logic [31:0]          cnt_q, cnt_d;

  assign issue_ready = ~|lk_q;
  assign wb_ready    = '1;
  assign warp_busy   = busy_q;
  assign err_release = err_q;
  assign deadlock    = dead_q;

  // Ordering matters: flush, then releases, then reserve wins.
  always_comb begin
    inuse_d = inuse_q;
    err_d   = err_q;
    if (flush_valid)
      inuse_d[flush_wid] = '0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid[p] && wb_eop[p]) begin
        if (!inuse_q[wb_wid[p*WW +: WW]][wb_rd[p*RW +: RW]])
          err_d = 1'b1;
        inuse_d[wb_wid[p*WW +: WW]][wb_rd[p*RW +: RW]] = 1'b0;
      end
    end
    if (issue_valid && issue_ready && issue_wb)
      inuse_d[issue_wid][issue_rd] = 1'b1;
  end

  always_comb begin
    lk_d = {inuse_d[next_wid][next_rs3],
            inuse_d[next_wid][next_rs2],
            inuse_d[next_wid][next_rs1],
            inuse_d[next_wid][next_rd]};
    for (int w = 0; w < NUM_WARPS; w++)
      busy_d[w] = |inuse_d[w];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (issue_valid && issue_ready)
      cnt_d = '0;
    else if (issue_valid && cnt_q < TO)
      cnt_d = cnt_q + 32'd1;
    dead_d = dead_q | (cnt_d == TO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inuse_q <= '0;
      lk_q    <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
      dead_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      inuse_q <= inuse_d;
      lk_q    <= lk_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      dead_q  <= dead_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_vx_scoreboard_mp.sv
// Randomized and directed bench for vx_scoreboard_mp.
// A reference table model predicts outputs into a queue; a monitor checks them.
module tb_vx_scoreboard_mp;

  localparam int NW = 4;
  localparam int NR = 16;
  localparam int NB = 2;
  localparam int TO = 8;
  localparam int WW = 2;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic issue_valid = 0, issue_wb = 0;
  logic issue_ready;
  logic [WW-1:0] issue_wid = '0, next_wid = '0, flush_wid = '0;
  logic [RW-1:0] issue_rd = '0;
  logic [RW-1:0] next_rd = '0, next_rs1 = '0;
  logic [RW-1:0] next_rs2 = '0, next_rs3 = '0;
  logic [NB-1:0] wb_valid = '0, wb_eop = '0, wb_ready;
  logic [NB*WW-1:0] wb_wid = '0;
  logic [NB*RW-1:0] wb_rd = '0;
  logic flush_valid = 0;
  logic [NW-1:0] warp_busy;
  logic err_release, deadlock;

  vx_scoreboard_mp #(
    .NUM_WARPS(NW), .NUM_REGS(NR),
    .NUM_WB(NB), .DEADLOCK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_wid(issue_wid), .issue_wb(issue_wb),
    .issue_rd(issue_rd),
    .next_wid(next_wid), .next_rd(next_rd),
    .next_rs1(next_rs1), .next_rs2(next_rs2),
    .next_rs3(next_rs3),
    .wb_valid(wb_valid), .wb_eop(wb_eop),
    .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_ready(wb_ready),
    .flush_valid(flush_valid), .flush_wid(flush_wid),
    .warp_busy(warp_busy), .err_release(err_release),
    .deadlock(deadlock)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rdy;
    logic [NW-1:0] busy;
    logic          err;
    logic          dead;
    logic [NB-1:0] wbr;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  bit mdl[NW][NR];
  bit m_ready = 1;
  bit [NW-1:0] m_busy;
  bit m_err, m_dead;
  int m_cnt;

  task automatic chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", nm, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("issue_ready", int'(issue_ready), int'(e.rdy));
        chk("warp_busy", int'(warp_busy), int'(e.busy));
        chk("err_release", int'(err_release), int'(e.err));
        chk("deadlock", int'(deadlock), int'(e.dead));
        chk("wb_ready", int'(wb_ready), int'(e.wbr));
      end
    end
  end

  // Reference: apply the cycle's rules to a plain bit table.
  task automatic step();
    bit nx[NW][NR];
    bit acc;
    int w, r;
    exp_t e;
    if (reset) begin
      foreach (mdl[i, j]) mdl[i][j] = 0;
      m_ready = 1; m_busy = '0;
      m_err = 0; m_dead = 0; m_cnt = 0;
    end else begin
      acc = issue_valid && m_ready;
      if (acc) m_cnt = 0;
      else if (issue_valid && m_cnt < TO) m_cnt++;
      if (m_cnt == TO) m_dead = 1;
      nx = mdl;
      if (flush_valid)
        for (int j = 0; j < NR; j++) nx[flush_wid][j] = 0;
      for (int p = 0; p < NB; p++)
        if (wb_valid[p] && wb_eop[p]) begin
          w = int'(wb_wid[p*WW +: WW]);
          r = int'(wb_rd[p*RW +: RW]);
          if (!mdl[w][r]) m_err = 1;
          nx[w][r] = 0;
        end
      if (acc && issue_wb) nx[issue_wid][issue_rd] = 1;
      mdl = nx;
      m_ready = !(mdl[next_wid][next_rd] || mdl[next_wid][next_rs1]
               || mdl[next_wid][next_rs2] || mdl[next_wid][next_rs3]);
      for (int i = 0; i < NW; i++) begin
        m_busy[i] = 0;
        for (int j = 0; j < NR; j++)
          if (mdl[i][j]) m_busy[i] = 1;
      end
    end
    e.rdy = m_ready; e.busy = m_busy;
    e.err = m_err; e.dead = m_dead; e.wbr = '1;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    step();
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; issue_valid = 0; issue_wb = 0;
    wb_valid = '0; wb_eop = '0; flush_valid = 0;
  endtask

  task automatic look(int w, int rd, int a, int b, int c);
    next_wid = WW'(w); next_rd = RW'(rd);
    next_rs1 = RW'(a); next_rs2 = RW'(b); next_rs3 = RW'(c);
  endtask

  task automatic issue(int w, int rd, bit wb);
    issue_valid = 1; issue_wid = WW'(w);
    issue_rd = RW'(rd); issue_wb = wb;
  endtask

  task automatic rel(int p, int w, int rd);
    wb_valid[p] = 1; wb_eop[p] = 1;
    wb_wid[p*WW +: WW] = WW'(w);
    wb_rd[p*RW +: RW] = RW'(rd);
  endtask

  task automatic do_reset();
    idle(); reset = 1; tick(); reset = 0;
  endtask

  initial begin
    int pw, pr;
    @(negedge clk);
    do_reset();
    tick();
    // reserve w1/r5, lookahead depends on it, release later on port 1
    look(1, 0, 5, 0, 0); issue(1, 5, 1); tick();
    idle(); tick(); tick();
    rel(1, 1, 5); tick();
    idle(); tick();
    // two ports release distinct reserved bits together
    look(3, 15, 15, 15, 15);
    issue(0, 3, 1); tick();
    issue(2, 7, 1); tick();
    idle(); rel(0, 0, 3); rel(1, 2, 7); tick();
    idle(); tick();
    // release of never-reserved bit
    rel(0, 0, 9); tick();
    idle(); tick(); tick();
    do_reset();
    // flush with concurrent reserve
    look(3, 15, 15, 15, 15);
    issue(2, 1, 1); tick();
    issue(2, 2, 1); tick();
    issue(2, 4, 1); flush_valid = 1; flush_wid = 2; tick();
    idle(); tick();
    // stall until deadlock
    do_reset();
    look(3, 15, 15, 15, 15);
    issue(0, 6, 1); tick();
    look(0, 1, 2, 6, 3); issue(0, 1, 0);
    repeat (12) tick();
    idle(); tick();
    do_reset();
    tick();
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(149) == 0) reset = 1;
      if ($urandom_range(3) != 0)
        issue($urandom_range(NW-1), $urandom_range(7), 1'($urandom));
      look($urandom_range(NW-1), $urandom_range(7), $urandom_range(7),
           $urandom_range(7), $urandom_range(7));
      for (int p = 0; p < NB; p++) begin
        if ($urandom_range(2) == 0) begin
          pw = $urandom_range(NW-1); pr = $urandom_range(7);
          if ($urandom_range(15) != 0)
            for (int k = 0; k < 16; k++)
              if (!mdl[pw][pr]) begin
                pw = $urandom_range(NW-1); pr = $urandom_range(7);
              end
          rel(p, pw, pr);
          if ($urandom_range(3) == 0) wb_eop[p] = 0;
        end
      end
      if ($urandom_range(39) == 0) begin
        flush_valid = 1; flush_wid = WW'($urandom_range(NW-1));
      end
      tick();
    end
    idle();
    tick();
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_scoreboard_mp.md
VX_SCOREBOARD_MP -- requirements
Module: VX_scoreboard_mp

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warps tracked (power of 2, >=2).
REQ-002 SHALL have parameter NUM_REGS, default 64, architectural registers per warp (power of 2).
REQ-003 SHALL have parameter NUM_WB, default 2, independent writeback ports (>=1).
REQ-004 SHALL have parameter DEADLOCK_TIMEOUT, default 10000, stall cycles before deadlock is flagged.
REQ-005 SHALL define WW = clog2(NUM_WARPS) and RW = clog2(NUM_REGS).
REQ-006 SHALL have ports, clock and reset first:
- clk  in  1  clock; reset reset, synchronous, active-high; clock clk
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  issue entry present
- issue_ready  out  1  entry hazard-free; accepted when valid&&ready
- issue_wid  in  WW  warp of current entry
- issue_wb  in  1  entry writes rd
- issue_rd  in  RW  destination register
- next_wid  in  WW  warp of entry presented next cycle (lookahead)
- next_rd, next_rs1, next_rs2, next_rs3  in  RW each  operands of next-cycle entry
- wb_valid  in  NUM_WB  per-port writeback valid
- wb_eop  in  NUM_WB  per-port last packet of instruction
- wb_wid  in  NUM_WB*WW  per-port warp, port p at [p*WW +: WW]
- wb_rd  in  NUM_WB*RW  per-port register, port p at [p*RW +: RW]
- wb_ready  out  NUM_WB  constant all-ones
- flush_valid  in  1  clear all reservations of flush_wid
- flush_wid  in  WW  warp to flush
- warp_busy  out  NUM_WARPS  registered: warp has >=1 reserved register
- err_release  out  1  sticky: release of unreserved register
- deadlock  out  1  sticky: stall reached DEADLOCK_TIMEOUT

Function
REQ-007 SHALL hold state inuse[NUM_WARPS][NUM_REGS], one bit each.
REQ-008 SHALL compute next state inuse_n in this order: copy inuse; apply flush (clear row flush_wid); apply each port p with wb_valid[p]&&wb_eop[p] (clear bit); apply reserve when issue_valid&&issue_ready&&issue_wb (set bit issue_wid/issue_rd).
REQ-009 SHALL let reserve win over flush or release to the same bit in the same cycle.
REQ-010 SHALL treat wb_valid without wb_eop as no state change.
REQ-011 SHALL allow multiple ports to release the same bit in one cycle without error, provided the bit was set in inuse.
REQ-012 SHALL register four lookup bits each cycle from inuse_n indexed by next_wid with next_rd, next_rs1, next_rs2, next_rs3.
REQ-013 SHALL drive issue_ready = NOR of the four registered lookup bits (one-cycle lookup latency, no combinational path from issue_* to issue_ready).
REQ-014 SHALL produce warp_busy[w] registered = OR of inuse_n row w.
REQ-015 SHALL set err_release when any releasing port targets a bit clear in inuse (pre-update), flush in the same cycle notwithstanding; held until reset.
REQ-016 SHALL keep a 32-bit stall counter: +1 on issue_valid&&!issue_ready, cleared on issue_valid&&issue_ready, held otherwise; saturates at DEADLOCK_TIMEOUT.
REQ-017 SHALL set deadlock when counter reaches DEADLOCK_TIMEOUT; held until reset.
REQ-018 SHALL be 1-deep in time: a release at cycle t makes the register available for an entry whose lookahead is presented at t, so issue_ready rises at t+1.

Reset
REQ-019 SHALL on reset clear inuse, lookup bits (issue_ready=1), warp_busy=0, err_release=0, deadlock=0, counter=0; reset mid-operation discards all reservations.

Verification
REQ-020 Reserve w1/r5 at t (wb=1); next entry w1 rs1=5 -> issue_ready=0 from t+1, warp_busy[1]=1; release on port 1 at t+3 -> issue_ready=1 at t+4, warp_busy[1]=0.
REQ-021 Ports 0/1 release w0/r3 and w2/r7 same cycle, both reserved -> both clear, err_release stays 0.
REQ-022 Release w0/r9 never reserved -> err_release=1 next cycle, persists until reset.
REQ-023 Flush w2 with r1,r2 reserved, concurrent reserve w2/r4 -> r1,r2 clear, r4 set, warp_busy[2]=1.
REQ-024 DEADLOCK_TIMEOUT=8, hold valid with rs2 reserved, no release -> deadlock=1 after 8 stall cycles; reset -> all outputs to reset values.
